// File: rtl/symbol_adjust_reflector_ctrl.sv
// symbol_adjust_reflector_ctrl
//   Coefficient scheduler for the symbol-adjust reflector datapath. The host
//   writes per-lane channel taps and shifts into shadow registers. A commit
//   request arms a swap, and the swap copies all shadow contents to the active
//   registers on the next frame boundary. After each swap, and after reset,
//   res_valid is held low for flush_cycles cycles. This lets stale products
//   drain out of the datapath.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   wr_valid/ready    shadow write handshake (ready is low only while ARMED)
//   wr_is_shift       1 = write the shift of wr_lane, 0 = write tap wr_tap
//   wr_lane, wr_tap   addresses; out-of-range writes are accepted and dropped
//   wr_data           signed tap value; low shift_bitwidth bits form a shift
//   commit_req        request a shadow->active swap
//   frame_strobe      frame boundary; a swap happens only here, while ARMED
//   channel_est       active taps   [width][depth]
//   channel_shift     active shifts [width]
//   res_valid         datapath residual-error outputs are trustworthy
//   busy              controller is in ARMED or BLANK
//   commit_count      number of completed swaps, modulo 256
module symbol_adjust_reflector_ctrl #(
  parameter int width                = 16,
  parameter int depth                = 30,
  parameter int est_channel_bitwidth = 10,
  parameter int shift_bitwidth       = 4,
  parameter int flush_cycles         = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic                                   wr_is_shift,
  input  logic [$clog2(width)-1:0]               wr_lane,
  input  logic [$clog2(depth)-1:0]               wr_tap,
  input  logic signed [est_channel_bitwidth-1:0] wr_data,
  input  logic                                   commit_req,
  input  logic                                   frame_strobe,
  output logic signed [est_channel_bitwidth-1:0] channel_est [width][depth],
  output logic [shift_bitwidth-1:0]              channel_shift [width],
  output logic                                   res_valid,
  output logic                                   busy,
  output logic [7:0]                             commit_count
);

  typedef enum logic [1:0] {IDLE, ARMED, BLANK} state_t;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       pending, pending_next;
  logic       swap;
  logic       wr_en;
  logic       lane_ok, tap_ok;

  logic signed [est_channel_bitwidth-1:0] shadow_est   [width][depth];
  logic [shift_bitwidth-1:0]              shadow_shift [width];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BLANK;
      cnt          <= 8'(flush_cycles);
      pending      <= 1'b0;
      commit_count <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pending <= pending_next;
      if (swap) commit_count <= commit_count + 8'd1;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = pending;
    swap         = 1'b0;
    wr_ready     = 1'b1;
    res_valid    = 1'b1;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (commit_req || pending) begin
          state_next   = ARMED;
          pending_next = 1'b0;
        end
      end
      ARMED: begin
        // commit_req is ignored here because a swap is already scheduled.
        wr_ready = 1'b0;
        if (frame_strobe) begin
          swap       = 1'b1;
          cnt_next   = 8'(flush_cycles);
          state_next = BLANK;
        end
      end
      BLANK: begin
        // A request during blanking is remembered and replayed through IDLE.
        res_valid = 1'b0;
        cnt_next  = cnt - 8'd1;
        if (commit_req) pending_next = 1'b1;
        if (cnt == 8'd1) state_next = IDLE;
      end
      default: state_next = BLANK;
    endcase
  end

  assign wr_en   = wr_valid && wr_ready;
  assign lane_ok = int'(wr_lane) < width;
  assign tap_ok  = int'(wr_tap) < depth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_est   <= '{default: '0};
      shadow_shift <= '{default: '0};
    end else if (wr_en && lane_ok) begin
      if (wr_is_shift)
        shadow_shift[wr_lane] <= wr_data[shift_bitwidth-1:0];
      else if (tap_ok)
        shadow_est[wr_lane][wr_tap] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      channel_est   <= '{default: '0};
      channel_shift <= '{default: '0};
    end else if (swap) begin
      channel_est   <= shadow_est;
      channel_shift <= shadow_shift;
    end
  end

endmodule
